// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - control/status bundle between the sequencer and the core
// Carries the step pulse only when SEQ_STEP_EN is defined.
interface instr_sequencer_if #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
);
    logic              run;
    logic              tu_tick;
    logic              is_slp;
    logic              is_jmp;
    logic [DATA_W-1:0] slp_val;
    logic [PC_W-1:0]   jmp_target;
`ifdef SEQ_STEP_EN
    logic              step;
`endif
    logic [PC_W-1:0]   pc;
    logic              fetch_en;
    logic              exec_en;
    logic              sleeping;
    logic              jmp_err;
    logic [CNT_W-1:0]  retired;

    modport master (
`ifdef SEQ_STEP_EN
        output step,
`endif
        output run, tu_tick, is_slp, is_jmp, slp_val, jmp_target,
        input  pc, fetch_en, exec_en, sleeping, jmp_err, retired
    );

    modport slave (
`ifdef SEQ_STEP_EN
        input  step,
`endif
        input  run, tu_tick, is_slp, is_jmp, slp_val, jmp_target,
        output pc, fetch_en, exec_en, sleeping, jmp_err, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/exec/sleep/jump control sequencer driving the program counter
// Optional single-step input enabled by defining SEQ_STEP_EN.
module instr_sequencer #(
    parameter int PROG_LEN = 14,
    parameter int PC_W     = 4,
    parameter int DATA_W   = 11,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    instr_sequencer_if.slave seq
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, SLEEP} state_t;

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);
    localparam logic [PC_W:0]   PC_END  = (PC_W+1)'(PROG_LEN);

    state_t            state, state_next;
    logic [PC_W-1:0]   pc_q, pc_next, pc_inc;
    logic [DATA_W-1:0] cnt_q, cnt_next;
    logic              err_q, err_next;
    logic [CNT_W-1:0]  retired_q;
    logic              slp_pos;
    logic              go_on;
    logic              fetch_en_c, exec_en_c, sleeping_c;

    assign pc_inc  = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
    assign slp_pos = !seq.slp_val[DATA_W-1] && (seq.slp_val != '0);

`ifdef SEQ_STEP_EN
    logic step_mode_q, step_mode_next;
    // A stepped instruction always falls back to IDLE, whatever run does meanwhile.
    assign go_on = seq.run && !step_mode_q;
`else
    assign go_on = seq.run;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        cnt_next   = cnt_q;
        err_next   = err_q;
        fetch_en_c = 1'b0;
        exec_en_c  = 1'b0;
        sleeping_c = 1'b0;
`ifdef SEQ_STEP_EN
        step_mode_next = step_mode_q;
`endif
        case (state)
            IDLE: begin
                if (seq.run) begin
                    state_next = FETCH;
`ifdef SEQ_STEP_EN
                    step_mode_next = 1'b0;
                end else if (seq.step) begin
                    state_next     = FETCH;
                    step_mode_next = 1'b1;
`endif
                end
            end
            FETCH: begin
                fetch_en_c = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                exec_en_c  = 1'b1;
                state_next = go_on ? FETCH : IDLE;
                if (seq.is_jmp) begin
                    if ({1'b0, seq.jmp_target} < PC_END) begin
                        pc_next = seq.jmp_target;
                    end else begin
                        pc_next  = '0;
                        err_next = 1'b1;
                    end
                    // Sleep alongside a jump is dropped and flagged.
                    if (seq.is_slp) err_next = 1'b1;
                end else begin
                    pc_next = pc_inc;
                    if (seq.is_slp && slp_pos) begin
                        cnt_next   = seq.slp_val;
                        state_next = SLEEP;
                    end
                end
            end
            SLEEP: begin
                sleeping_c = 1'b1;
                if (seq.tu_tick) begin
                    cnt_next = cnt_q - 1'b1;
                    if (cnt_q == DATA_W'(1)) state_next = go_on ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
`ifdef SEQ_STEP_EN
            step_mode_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            cnt_q <= cnt_next;
            err_q <= err_next;
            if (state == EXEC) retired_q <= retired_q + CNT_W'(1);
`ifdef SEQ_STEP_EN
            step_mode_q <= step_mode_next;
`endif
        end
    end

    assign seq.pc       = pc_q;
    assign seq.fetch_en = fetch_en_c;
    assign seq.exec_en  = exec_en_c;
    assign seq.sleeping = sleeping_c;
    assign seq.jmp_err  = err_q;
    assign seq.retired  = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed and randomized checks of instr_sequencer against an instruction-level model
module tb_instr_sequencer;
    localparam int PROG_LEN = 14;

    logic clk;
    logic reset;
    int   passes;
    int   total;
    int   m_pc;
    int   m_ret;
    int   m_err;

    instr_sequencer_if #(.PC_W(4), .DATA_W(11), .CNT_W(16)) u_if ();

    instr_sequencer #(.PROG_LEN(PROG_LEN), .PC_W(4), .DATA_W(11), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .seq   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        u_if.run  = 1'b0;
        tick();
        reset = 1'b0;
        m_pc  = 0;
        m_ret = 0;
        m_err = 0;
        check("rst_pc", 32'(u_if.pc), 0);
        check("rst_fetch", 32'(u_if.fetch_en), 0);
        check("rst_exec", 32'(u_if.exec_en), 0);
        check("rst_sleep", 32'(u_if.sleeping), 0);
        check("rst_err", 32'(u_if.jmp_err), 0);
        check("rst_retired", 32'(u_if.retired), 0);
    endtask

    // Entry point: just after the edge that entered FETCH. Exit: same place for the next instruction.
    task automatic exec_instr(input logic j, input logic s, input int sv, input int tg,
                              input int gap, input logic stop);
        int sleep_len;
        check("fetch_en", 32'(u_if.fetch_en), 1);
        check("fetch_pc", 32'(u_if.pc), 32'(m_pc));
        check("fetch_noexec", 32'(u_if.exec_en), 0);
        tick();
        check("exec_en", 32'(u_if.exec_en), 1);
        check("exec_pc", 32'(u_if.pc), 32'(m_pc));
        check("exec_nofetch", 32'(u_if.fetch_en), 0);
        u_if.is_jmp     = j;
        u_if.is_slp     = s;
        u_if.slp_val    = sv[10:0];
        u_if.jmp_target = tg[3:0];
        u_if.tu_tick    = 1'($urandom_range(1));
        if (stop) u_if.run = 1'b0;

        sleep_len = 0;
        m_ret = (m_ret + 1) % 65536;
        if (j) begin
            if (tg < PROG_LEN) m_pc = tg;
            else begin
                m_pc  = 0;
                m_err = 1;
            end
            if (s) m_err = 1;
        end else begin
            m_pc = (m_pc + 1) % PROG_LEN;
            if (s && sv > 0) sleep_len = sv;
        end

        tick();
        u_if.is_jmp  = 1'b0;
        u_if.is_slp  = 1'b0;
        u_if.tu_tick = 1'b0;
        check("retired", 32'(u_if.retired), 32'(m_ret));
        check("jmp_err", 32'(u_if.jmp_err), 32'(m_err));
        check("post_exec_off", 32'(u_if.exec_en), 0);
        check("sleep_entry", 32'(u_if.sleeping), 32'(sleep_len > 0));
        for (int k = 0; k < sleep_len; k++) begin
            for (int g = 0; g < gap; g++) begin
                check("sleeping", 32'(u_if.sleeping), 1);
                check("sleep_pc", 32'(u_if.pc), 32'(m_pc));
                tick();
            end
            u_if.tu_tick = 1'b1;
            tick();
            u_if.tu_tick = 1'b0;
        end
        if (!u_if.run) begin
            for (int i = 0; i < 2; i++) begin
                check("idle_fetch", 32'(u_if.fetch_en), 0);
                check("idle_exec", 32'(u_if.exec_en), 0);
                check("idle_sleep", 32'(u_if.sleeping), 0);
                check("idle_pc", 32'(u_if.pc), 32'(m_pc));
                tick();
            end
            u_if.run = 1'b1;
            tick();
        end
    endtask

    initial begin
        passes          = 0;
        total           = 0;
        reset           = 1'b1;
        u_if.run        = 1'b0;
        u_if.tu_tick    = 1'b0;
        u_if.is_slp     = 1'b0;
        u_if.is_jmp     = 1'b0;
        u_if.slp_val    = '0;
        u_if.jmp_target = '0;
`ifdef SEQ_STEP_EN
        u_if.step = 1'b0;
`endif
        tick();
        do_reset();

        // Free run of 15 plain instructions wraps pc 13 -> 0.
        u_if.run = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) exec_instr(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("wrap_retired", 32'(u_if.retired), 15);

        while (m_pc != 5) exec_instr(1'b0, 1'b0, 0, 0, 0, 1'b0);
        exec_instr(1'b1, 1'b0, 0, 2, 0, 1'b0);
        check("jump_pc", 32'(u_if.pc), 2);

        exec_instr(1'b0, 1'b0, 0, 0, 0, 1'b0);
        exec_instr(1'b0, 1'b1, 3, 0, 3, 1'b0);
        check("after_sleep_pc", 32'(u_if.pc), 4);
        exec_instr(1'b0, 1'b1, -5, 0, 3, 1'b0);
        check("neg_sleep_pc", 32'(u_if.pc), 5);

        exec_instr(1'b0, 1'b0, 0, 0, 0, 1'b1);

        // Reset lands in the middle of a sleep with two units left.
        tick();
        u_if.is_slp  = 1'b1;
        u_if.slp_val = 11'd3;
        tick();
        u_if.is_slp  = 1'b0;
        u_if.tu_tick = 1'b1;
        tick();
        u_if.tu_tick = 1'b0;
        check("pre_reset_sleep", 32'(u_if.sleeping), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_pc  = 0;
        m_ret = 0;
        m_err = 0;
        check("midsleep_rst_sleep", 32'(u_if.sleeping), 0);
        check("midsleep_rst_pc", 32'(u_if.pc), 0);
        check("midsleep_rst_ret", 32'(u_if.retired), 0);
        check("midsleep_rst_fetch", 32'(u_if.fetch_en), 0);
        tick();

        exec_instr(1'b1, 1'b1, 4, 7, 1, 1'b0);
        check("jmp_slp_pc", 32'(u_if.pc), 7);
        check("jmp_slp_err", 32'(u_if.jmp_err), 1);

        do_reset();
        u_if.run = 1'b1;
        tick();
        exec_instr(1'b1, 1'b0, 0, 15, 0, 1'b0);
        for (int i = 0; i < 3; i++) exec_instr(1'b0, 1'b0, 0, 0, 0, 1'b0);
        check("err_sticky", 32'(u_if.jmp_err), 1);

        do_reset();
        u_if.run = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            exec_instr(1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0),
                       int'($urandom_range(12)) - 6, int'($urandom_range(15)),
                       int'($urandom_range(3)), 1'($urandom_range(7) == 0));
        end

`ifdef SEQ_STEP_EN
        begin
            int pulses;
            do_reset();
            u_if.step = 1'b1;
            tick();
            u_if.step = 1'b0;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                if (u_if.exec_en) pulses++;
                tick();
            end
            check("step_pulses", 32'(pulses), 1);
            check("step_retired", 32'(u_if.retired), 1);
            check("step_pc", 32'(u_if.pc), 1);
            check("step_idle", 32'(u_if.fetch_en), 0);
        end
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control sequencer for the MCxxxx-style core. Drives the program counter and the fetch and execute strobes.
- Consumes the decoder flags (is_slp, is_jmp) plus operand values, and implements sleep (time-unit wait) and jump control flow.
- Sits between the instruction ROM and the decode LUT / register-file write path. Register writes are gated by exec_en.

Parameters:
PROG_LEN, 14, number of program lines; PC wraps from PROG_LEN-1 to 0
PC_W, 4, program counter width; must satisfy 2**PC_W >= PROG_LEN
DATA_W, 11, signed width of the sleep operand (range -1024..1023)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
run  in  1  level; 1 = execute program, 0 = stop at next instruction boundary
tu_tick  in  1  one-cycle pulse marking one time unit
is_slp  in  1  decoder flag, sampled in EXEC
is_jmp  in  1  decoder flag, sampled in EXEC
slp_val  in  DATA_W  signed sleep operand (register or immediate), sampled in EXEC
jmp_target  in  PC_W  jump destination line, sampled in EXEC
pc  out  PC_W  current program line, ROM address
fetch_en  out  1  ROM read enable; synchronous read, data valid next cycle
exec_en  out  1  one-cycle strobe; instruction commits (register write allowed)
sleeping  out  1  high while in SLEEP
jmp_err  out  1  sticky; out-of-range jump or illegal flag combination
retired  out  CNT_W  count of committed instructions, wraps modulo 2**CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: state=IDLE, pc=0, fetch_en=0, exec_en=0, sleeping=0, jmp_err=0, retired=0, sleep counter=0.
- Reset mid-operation (including mid-SLEEP) aborts immediately to the reset values.

States:
- IDLE: all strobes 0. If run=1, go to FETCH.
- FETCH: fetch_en=1 for exactly one cycle, then go to EXEC.
- EXEC: exec_en=1 for exactly one cycle. retired increments. Flags and operands are sampled. Next state:
  - is_jmp=1: pc <= jmp_target if jmp_target < PROG_LEN; otherwise pc <= 0 and jmp_err <= 1.
  - is_slp=1 and slp_val > 0: load counter with slp_val, pc <= pc+1 (wrapped), go to SLEEP.
  - is_slp=1 and slp_val <= 0: treated as NOP (pc+1, no wait).
  - Otherwise: pc <= pc+1; if pc == PROG_LEN-1, pc <= 0.
  - Next state after a non-sleep instruction: FETCH if run=1, else IDLE.
  - is_jmp and is_slp both 1: jump takes priority, sleep is ignored, jmp_err <= 1.
- SLEEP: sleeping=1. Each tu_tick decrements the counter.
  - When a tick brings the counter to 0: go to FETCH if run=1, else IDLE. This happens on the same edge.
  - A tu_tick during EXEC (the load cycle) is not counted.
  - run=0 during SLEEP does not abort the sleep. It is honoured when the sleep completes.

Timing and counters:
- Non-sleep instruction latency is 2 cycles (FETCH, EXEC). Back-to-back throughput is 1 instruction per 2 cycles.
- pc is stable from FETCH through EXEC and changes only on the EXEC→next edge.
- retired is unsigned and wraps from 2**CNT_W-1 to 0.
- jmp_err is cleared only by reset.

Optional Feature:
SEQ_STEP_EN
- Defined: adds input port step (1 bit, pulse). In IDLE with run=0, a step pulse runs exactly one FETCH+EXEC, including any SLEEP the instruction starts, then returns to IDLE. step is ignored outside IDLE and when run=1.
- Undefined: no step port; IDLE is left only via run=1.

Test Plan:
- Reset, then run=1 with no flags for 30 cycles → pc sequence 0,0,1,1,…; pc wraps 13→0 after 28 cycles; retired=15.
- EXEC at pc=5 with is_jmp=1, jmp_target=2 → next fetch at pc=2. jmp_target=15 → pc=0, jmp_err=1 and stays 1.
- EXEC at pc=3 with is_slp=1, slp_val=3, ticks every 4 cycles → sleeping=1 until the 3rd tick, then FETCH at pc=4. slp_val=-5 → no sleep, pc=4 two cycles later.
- is_slp=1 and is_jmp=1, jmp_target=7 → pc=7, no SLEEP entered, jmp_err=1.
- Reset asserted in SLEEP with counter=2 → next cycle: IDLE, pc=0, sleeping=0, retired=0. Drop run during EXEC → IDLE after EXEC; pc holds at the incremented value.
- With SEQ_STEP_EN defined, run=0 and a step pulse → exactly one exec_en pulse, retired +1, return to IDLE.
